// File: rtl/signed_count_monitor_if.sv
// Sample/result bus for signed_count_monitor: sample strobe in, windowed result out over VALID/READY.
// DROPS exists only when SIGNED_COUNT_MONITOR_DROP_EN is defined.
interface signed_count_monitor_if #(
  parameter int unsigned DW = 4,
  parameter int unsigned AW = 8
);
  logic          CE;
  logic [DW-1:0] D;
  logic [AW-1:0] Q;
  logic [3:0]    WRAPS;
  logic          OVF;
  logic          VALID;
  logic          READY;
`ifdef SIGNED_COUNT_MONITOR_DROP_EN
  logic [7:0]    DROPS;
`endif

  modport master (
    output CE,
    output D,
    output READY,
    input  Q,
    input  WRAPS,
    input  OVF,
`ifdef SIGNED_COUNT_MONITOR_DROP_EN
    input  DROPS,
`endif
    input  VALID
  );

  modport slave (
    input  CE,
    input  D,
    input  READY,
    output Q,
    output WRAPS,
    output OVF,
`ifdef SIGNED_COUNT_MONITOR_DROP_EN
    output DROPS,
`endif
    output VALID
  );
endinterface

// File: rtl/signed_count_monitor.sv
// Sums N signed samples into a saturating accumulator, counts +max -> -min wraps, and presents each
// window result over VALID/READY. Optional DROPS counter: SIGNED_COUNT_MONITOR_DROP_EN.
module signed_count_monitor #(
  parameter int unsigned DW = 4,
  parameter int unsigned AW = 8,
  parameter int unsigned N  = 8
) (
  input logic                  C,
  input logic                  CLR,
  signed_count_monitor_if.slave bus
);

  typedef enum logic [0:0] {StAcc, StHold} state_e;

  state_e        r_state;
  logic [AW-1:0] r_acc;
  logic [7:0]    r_cnt;
  logic [3:0]    r_wraps;
  logic          r_ovf;
  logic [DW-1:0] r_prev;
  logic [AW-1:0] r_q;
  logic [3:0]    r_q_wraps;
  logic          r_q_ovf;
  logic          r_valid;
`ifdef SIGNED_COUNT_MONITOR_DROP_EN
  logic [7:0]    r_drops;
`endif

  logic [AW:0]   w_sum;
  logic          w_sat;
  logic [AW-1:0] w_acc_nxt;
  logic          w_wrap;
  logic [3:0]    w_wraps_nxt;
  logic          w_ovf_nxt;
  logic          w_last;

  // One guard bit: overflow when the two top bits of the widened sum disagree.
  always_comb begin
    w_sum     = {r_acc[AW-1], r_acc} + {{(AW - DW + 1){bus.D[DW-1]}}, bus.D};
    w_sat     = w_sum[AW] ^ w_sum[AW-1];
    w_acc_nxt = w_sum[AW-1:0];
    if (w_sat) begin
      w_acc_nxt = w_sum[AW] ? {1'b1, {(AW - 1){1'b0}}} : {1'b0, {(AW - 1){1'b1}}};
    end
    w_wrap      = (r_prev == {1'b0, {(DW - 1){1'b1}}}) && (bus.D == {1'b1, {(DW - 1){1'b0}}});
    w_wraps_nxt = (w_wrap && (r_wraps != 4'hf)) ? r_wraps + 4'd1 : r_wraps;
    w_ovf_nxt   = r_ovf | w_sat;
    w_last      = (r_cnt == 8'(N - 1));
  end

  always_ff @(posedge C) begin
    if (CLR) begin
      r_state   <= StAcc;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_wraps   <= '0;
      r_ovf     <= 1'b0;
      r_prev    <= '0;
      r_q       <= '0;
      r_q_wraps <= '0;
      r_q_ovf   <= 1'b0;
      r_valid   <= 1'b0;
`ifdef SIGNED_COUNT_MONITOR_DROP_EN
      r_drops   <= '0;
`endif
    end else begin
      unique case (r_state)
        StAcc: begin
          if (bus.CE) begin
            r_prev <= bus.D;
            if (w_last) begin
              r_q       <= w_acc_nxt;
              r_q_wraps <= w_wraps_nxt;
              r_q_ovf   <= w_ovf_nxt;
              r_valid   <= 1'b1;
              r_state   <= StHold;
              r_acc     <= '0;
              r_cnt     <= '0;
              r_wraps   <= '0;
              r_ovf     <= 1'b0;
`ifdef SIGNED_COUNT_MONITOR_DROP_EN
              r_drops   <= '0;
`endif
            end else begin
              r_acc   <= w_acc_nxt;
              r_cnt   <= r_cnt + 8'd1;
              r_wraps <= w_wraps_nxt;
              r_ovf   <= w_ovf_nxt;
            end
          end
        end
        StHold: begin
          // Samples are discarded here, but prev still tracks so boundary wraps are seen.
          if (bus.CE) begin
            r_prev <= bus.D;
`ifdef SIGNED_COUNT_MONITOR_DROP_EN
            if (r_drops != 8'hff) r_drops <= r_drops + 8'd1;
`endif
          end
          if (bus.READY) begin
            r_valid <= 1'b0;
            r_state <= StAcc;
          end
        end
        default: r_state <= StAcc;
      endcase
    end
  end

  assign bus.Q     = r_q;
  assign bus.WRAPS = r_q_wraps;
  assign bus.OVF   = r_q_ovf;
  assign bus.VALID = r_valid;
`ifdef SIGNED_COUNT_MONITOR_DROP_EN
  assign bus.DROPS = r_drops;
`endif

endmodule
